// File: rtl/axi_csr_regfile_if.sv
// AXI4 slave bus bundle for axi_csr_regfile: AW/W/B write channels and AR/R read channels.
// The master modport drives requests; the slave modport is used by the register file.
interface axi_csr_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned ID_W   = 5
);
  logic [ADDR_W-1:0]   awaddr;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [ID_W-1:0]     rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awid, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arid, arlen, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rdata, rid, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awid, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arid, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rdata, rid, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_csr_regfile.sv
// AXI4 slave CSR register file with INCR bursts, SLVERR on unmapped indices and independent
// write/read FSMs. Optional feature macro: CSR_RO_MASK_EN (enables RO_MASK write protection).
module axi_csr_regfile #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 5,
  parameter int unsigned          ID_W     = 5,
  parameter int unsigned          NUM_REGS = 32,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
  input logic              s_aclk,
  input logic              s_areset,
  axi_csr_regfile_if.slave s_axi
);

  localparam int unsigned StrbW      = DATA_W / 8;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  function automatic logic is_mapped(input logic [ADDR_W-1:0] idx);
    return {1'b0, idx} < (ADDR_W + 1)'(NUM_REGS);
  endfunction

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Write channel state
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [7:0]        w_len_q, w_len_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              w_last_beat;
  logic              w_beat_err;
  logic              w_mapped;
  logic              w_ro;

  // Read channel state
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              rd_mapped;

  assign w_mapped = is_mapped(w_addr_q);

`ifdef CSR_RO_MASK_EN
  always_comb begin
    w_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADDR_W'(i) == w_addr_q) w_ro = RO_MASK[i];
    end
  end
`else
  logic unused_ro_mask;
  assign unused_ro_mask = ^RO_MASK;
  assign w_ro = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write FSM and register update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d   = w_state_q;
    w_addr_d    = w_addr_q;
    w_id_d      = w_id_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    regs_d      = regs_q;
    w_last_beat = (w_cnt_q == w_len_q);
    w_beat_err  = !w_mapped || w_ro || (s_axi.wlast != w_last_beat);

    unique case (w_state_q)
      WIdle: begin
        if (s_axi.awvalid) begin
          w_addr_d  = s_axi.awaddr;
          w_id_d    = s_axi.awid;
          w_len_d   = s_axi.awlen;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi.wvalid) begin
          if (w_mapped && !w_ro) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (ADDR_W'(i) == w_addr_q) begin
                for (int b = 0; b < StrbW; b++) begin
                  if (s_axi.wstrb[b]) regs_d[i][8*b +: 8] = s_axi.wdata[8*b +: 8];
                end
              end
            end
          end
          w_addr_d = w_addr_q + 1'b1;
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q | w_beat_err;
          // Beat count alone terminates the burst; wlast only feeds the error flag.
          if (w_last_beat) begin
            w_state_d = WResp;
            bid_d     = w_id_q;
            bresp_d   = (w_err_q | w_beat_err) ? RespSlverr : RespOkay;
          end
        end
      end
      WResp: begin
        if (s_axi.bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      w_state_q <= WIdle;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: beats sample regs_q, so a same-edge write is seen only by later beats
  // ---------------------------------------------------------------------------
  assign rd_idx    = (r_state_q == RIdle) ? s_axi.araddr : r_addr_q;
  assign rd_mapped = is_mapped(rd_idx);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADDR_W'(i) == rd_idx) rd_word = regs_q[i];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;

    unique case (r_state_q)
      RIdle: begin
        if (s_axi.arvalid) begin
          r_state_d = RData;
          r_addr_d  = s_axi.araddr + 1'b1;
          r_len_d   = s_axi.arlen;
          r_cnt_d   = '0;
          rid_d     = s_axi.arid;
          rdata_d   = rd_mapped ? rd_word : '0;
          rresp_d   = rd_mapped ? RespOkay : RespSlverr;
          rlast_d   = (s_axi.arlen == 8'd0);
        end
      end
      RData: begin
        if (s_axi.rready) begin
          if (rlast_q) begin
            r_state_d = RIdle;
            rlast_d   = 1'b0;
          end else begin
            rdata_d  = rd_mapped ? rd_word : '0;
            rresp_d  = rd_mapped ? RespOkay : RespSlverr;
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = r_addr_q + 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= RespOkay;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s_axi.awready = (w_state_q == WIdle);
  assign s_axi.wready  = (w_state_q == WData);
  assign s_axi.bvalid  = (w_state_q == WResp);
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (r_state_q == RIdle);
  assign s_axi.rvalid  = (r_state_q == RData);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

endmodule

// File: tb/tb_axi_csr_regfile.sv
// Scoreboard bench for axi_csr_regfile: a reference register model predicts B and R results,
// which are queued at issue time and compared as the DUT returns them.
module tb_axi_csr_regfile;

  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 6;
  localparam int unsigned IdW     = 5;
  localparam int unsigned NumRegs = 32;
  localparam int unsigned IdxW    = 5;
  localparam logic [NumRegs-1:0] RoMask = 32'h0000_0004;
  localparam int Bound = 200;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [1:0]     resp;
  } b_exp_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [IdW-1:0]   id;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_csr_regfile_if #(.DATA_W(DataW), .ADDR_W(AddrW), .ID_W(IdW)) bus ();

  axi_csr_regfile #(
    .DATA_W  (DataW),
    .ADDR_W  (AddrW),
    .ID_W    (IdW),
    .NUM_REGS(NumRegs),
    .RO_MASK (RoMask)
  ) dut (
    .s_aclk  (clk),
    .s_areset(rst),
    .s_axi   (bus)
  );

  logic [DataW-1:0] model [NumRegs];
  b_exp_t b_q [$];
  r_exp_t r_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_ro(input logic [AddrW-1:0] a);
    logic ro;
    ro = 1'b0;
`ifdef CSR_RO_MASK_EN
    ro = RoMask[a[IdxW-1:0]];
`endif
    return ro;
  endfunction

  function automatic logic mapped(input logic [AddrW-1:0] a);
    return int'(a) < NumRegs;
  endfunction

  // bad_last: beat index whose wlast is inverted (-1 = well-formed burst)
  task automatic axi_write(input logic [AddrW-1:0] addr, input logic [IdW-1:0] id, input int len,
                           input logic [DataW-1:0] data0, input logic [3:0] strb,
                           input int bad_last);
    logic             err;
    logic [AddrW-1:0] a;
    logic [DataW-1:0] d;
    int               t;
    int               stalls;
    b_exp_t           e;
    err = 1'b0;
    a   = addr;
    for (int b = 0; b <= len; b++) begin
      d = data0 + DataW'(b);
      if (!mapped(a) || is_ro(a)) begin
        err = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (strb[k]) model[a[IdxW-1:0]][8*k +: 8] = d[8*k +: 8];
        end
      end
      if (b == bad_last) err = 1'b1;
      a = a + 1'b1;
    end
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

    @(negedge clk);
    bus.awaddr  = addr;
    bus.awid    = id;
    bus.awlen   = 8'(len);
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < Bound) begin
      @(negedge clk);
      t++;
    end
    check("aw_timeout", 64'(t < Bound), 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    stalls = 0;
    for (int b = 0; b <= len; b++) begin
      bus.wdata  = data0 + DataW'(b);
      bus.wstrb  = strb;
      bus.wlast  = (b == len) ^ (b == bad_last);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < Bound) begin
        @(negedge clk);
        t++;
        stalls++;
      end
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("w_stall_cycles", 64'(stalls), 64'd0);
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < Bound) begin
      @(negedge clk);
      t++;
    end
    check("b_timeout", 64'(t < Bound), 64'd1);
    if (b_q.size() == 0) begin
      check("b_queue_empty", 64'd1, 64'd0);
    end else begin
      e = b_q.pop_front();
      check("bid", 64'(bus.bid), 64'(e.id));
      check("bresp", 64'(bus.bresp), 64'(e.resp));
    end
    @(negedge clk);
    bus.bready = 1'b0;
    check("awready_after_b", 64'(bus.awready), 64'd1);
  endtask

  task automatic axi_read(input logic [AddrW-1:0] addr, input logic [IdW-1:0] id, input int len,
                          input bit toggle);
    logic [AddrW-1:0] a;
    r_exp_t           e;
    logic [34:0]      snap;
    bit               stalled;
    bit               rr;
    int               done;
    int               t;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      if (mapped(a)) r_q.push_back('{data: model[a[IdxW-1:0]], resp: 2'b00, last: b == len, id: id});
      else           r_q.push_back('{data: '0, resp: 2'b10, last: b == len, id: id});
      a = a + 1'b1;
    end

    @(negedge clk);
    bus.araddr  = addr;
    bus.arid    = id;
    bus.arlen   = 8'(len);
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < Bound) begin
      @(negedge clk);
      t++;
    end
    check("ar_timeout", 64'(t < Bound), 64'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;

    done    = 0;
    stalled = 1'b0;
    rr      = 1'b0;
    snap    = '0;
    t       = 0;
    while (done <= len && t < Bound) begin
      if (bus.rvalid) begin
        if (stalled) check("r_stable", 64'({bus.rdata, bus.rresp, bus.rlast}), 64'(snap));
        rr = toggle ? !rr : 1'b1;
        bus.rready = rr;
        if (rr) begin
          stalled = 1'b0;
          done++;
          if (r_q.size() == 0) begin
            check("r_queue_empty", 64'd1, 64'd0);
          end else begin
            e = r_q.pop_front();
            check("rdata", 64'(bus.rdata), 64'(e.data));
            check("rresp", 64'(bus.rresp), 64'(e.resp));
            check("rlast", 64'(bus.rlast), 64'(e.last));
            check("rid", 64'(bus.rid), 64'(e.id));
          end
        end else begin
          stalled = 1'b1;
          snap    = {bus.rdata, bus.rresp, bus.rlast};
        end
      end
      @(negedge clk);
      t++;
    end
    bus.rready = 1'b0;
    check("r_timeout", 64'(t < Bound), 64'd1);
    check("rvalid_after_last", 64'(bus.rvalid), 64'd0);
    check("arready_after_last", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    int t;
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < NumRegs; i++) model[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_bresp_bid", 64'({bus.bresp, bus.bid}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write/read
    axi_write(6'd3, 5'd7, 0, 32'hA5A5_5A5A, 4'hF, -1);
    axi_read(6'd3, 5'd9, 0, 1'b0);

    // Burst crossing into unmapped space
    axi_write(6'd30, 5'd2, 3, 32'h3000_0000, 4'hF, -1);
    axi_read(6'd30, 5'd3, 3, 1'b0);
    axi_read(6'd45, 5'd4, 0, 1'b0);

    // Partial strobes
    axi_write(6'd5, 5'd1, 0, 32'h1122_3344, 4'hF, -1);
    axi_write(6'd5, 5'd1, 0, 32'hFFFF_FFFF, 4'h5, -1);
    axi_read(6'd5, 5'd4, 0, 1'b0);

    // Long read burst with rready back-pressure
    axi_write(6'd0, 5'd6, 7, 32'h0100_0000, 4'hF, -1);
    axi_read(6'd0, 5'd6, 7, 1'b1);

    // wlast protocol errors: early and missing
    axi_write(6'd8, 5'd10, 1, 32'h0800_0000, 4'hF, 0);
    axi_write(6'd12, 5'd11, 2, 32'h0C00_0000, 4'hF, 2);
    axi_read(6'd8, 5'd12, 6, 1'b0);

    // Concurrent write and read
    fork
      axi_write(6'd10, 5'd13, 1, 32'h1010_0000, 4'hF, -1);
      axi_read(6'd3, 5'd14, 0, 1'b0);
    join
    axi_read(6'd10, 5'd15, 1, 1'b0);

    // Read-only register (effective only when the protection feature is built in)
    axi_write(6'd2, 5'd16, 0, 32'h0000_DEAD, 4'hF, -1);
    axi_read(6'd2, 5'd17, 0, 1'b0);

    // Asynchronous reset in the middle of a 4-beat write burst
    @(negedge clk);
    bus.awaddr = 6'd0; bus.awid = 5'd1; bus.awlen = 8'd3; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < Bound) begin
      @(negedge clk);
      t++;
    end
    check("rstmid_aw_timeout", 64'(t < Bound), 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wdata = 32'h7770_0000; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wdata = 32'h7770_0001;
    @(negedge clk);
    bus.wdata = 32'h7770_0002;
    #2 rst = 1'b1;
    #1;
    check("rstmid_awready", 64'(bus.awready), 64'd1);
    check("rstmid_wready", 64'(bus.wready), 64'd0);
    check("rstmid_bvalid", 64'(bus.bvalid), 64'd0);
    check("rstmid_rvalid", 64'(bus.rvalid), 64'd0);
    check("rstmid_bresp", 64'(bus.bresp), 64'd0);
    bus.wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NumRegs; i++) model[i] = '0;
    b_q.delete();
    r_q.delete();
    @(negedge clk);
    axi_read(6'd0, 5'd18, 3, 1'b0);
    axi_read(6'd5, 5'd19, 0, 1'b0);
    axi_write(6'd0, 5'd20, 0, 32'hCAFE_F00D, 4'hF, -1);
    axi_read(6'd0, 5'd21, 0, 1'b0);

    check("b_queue_drained", 64'(b_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_csr_regfile.md
Name:
axi_csr_regfile
Overview:
Parametrised AXI4 slave CSR register file, replacing the fixed 32x32 single-beat CSR block. Adds INCR bursts, a configurable register count/width, SLVERR on unmapped addresses, and back-to-back beat throughput. Independent write and read FSMs, one outstanding transaction per direction; sits on the CPU system interconnect.
Parameters:
DATA_W, 32, data width in bits (multiple of 8); strobe width DATA_W/8
ADDR_W, 5, word-index address width (address = register index, not byte address)
ID_W, 5, transaction ID width
NUM_REGS, 32, implemented registers (1..2^ADDR_W); index >= NUM_REGS unmapped
RO_MASK, 0, NUM_REGS-bit mask, bit i=1 makes register i read-only (used only with CSR_RO_MASK_EN)
Ports:
s_aclk  in  1  clock
s_areset  in  1  asynchronous reset, active-high
s_axi_awaddr  in  ADDR_W  write start register index
s_axi_awid  in  ID_W  write ID
s_axi_awlen  in  8  write beats minus 1
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bid  out  ID_W  response ID
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  response valid
s_axi_bready  in  1  response ready
s_axi_araddr  in  ADDR_W  read start register index
s_axi_arid  in  ID_W  read ID
s_axi_arlen  in  8  read beats minus 1
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_W  read data
s_axi_rid  out  ID_W  read ID
s_axi_rresp  out  2  per-beat response
s_axi_rlast  out  1  final read beat
s_axi_rvalid  out  1  read valid
s_axi_rready  in  1  read ready
Behaviour:
- Reset (async, any state): all registers 0; awready=arready=1; wready=bvalid=rvalid=rlast=0; bid/rid/bresp/rresp/rdata=0; both FSMs to IDLE; in-flight transactions dropped.
- Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: awready=1; AW handshake latches addr/id/len, clears error flag, awready=0, wready=1 next cycle. W_DATA: each W handshake writes strobed bytes to reg[addr] at that edge, addr+1 (wraps mod 2^ADDR_W), beat count+1; one beat per cycle, no bubbles. Unmapped beat: no write, sets error flag. wlast mismatch (set before final beat or clear on final) sets error flag; count (awlen+1) alone ends the burst. After final beat: wready=0, bvalid=1, bid=latched id, bresp=SLVERR if flag else OKAY. W_RESP: hold until bready; then awready=1 next cycle.
- Read FSM R_IDLE->R_DATA->R_IDLE. AR handshake at cycle N: rvalid=1 at N+1 with reg[araddr] (0 + SLVERR if unmapped), rid=arid, rlast=(arlen==0). On each R handshake, next beat loaded the following cycle (rvalid stays high, one beat/cycle); rdata/rresp/rlast held stable while rvalid && !rready. After last beat handshake: rvalid=0, arready=1 next cycle.
- Read data is sampled when the beat is loaded; a write at the same edge is not visible (read-before-write); visible on the next beat/transaction.
- Read and write FSMs fully independent; simultaneous AW and AR both accepted.
Optional Feature:
CSR_RO_MASK_EN defined: writes to registers with RO_MASK[i]=1 are discarded and set the write error flag (bresp SLVERR); reads unaffected. Undefined: RO_MASK ignored, all mapped registers writable.
Test Plan:
- Single write idx 3, wdata 0xA5A5_5A5A, wstrb 0xF, awid 7 -> bresp OKAY, bid 7; read idx 3 -> rdata 0xA5A5_5A5A, rlast=1, rid matches.
- INCR write awlen=3 start idx 30 (NUM_REGS 32), wvalid constant -> idx 30,31 written, bresp SLVERR; beats accepted on 4 consecutive cycles.
- Partial strobe: reg 5=0x1122_3344, write 0xFFFF_FFFF wstrb 0x5 -> reads 0x11FF_33FF.
- Read burst arlen=7 from idx 0, rready toggled 1/0 -> 8 beats, data stable while stalled, rlast only on beat 8, rresp OKAY.
- Async reset asserted mid write burst (beat 2 of 4) -> outputs at reset values immediately, regs 0, next AW accepted normally.
- CSR_RO_MASK_EN, RO_MASK bit 2=1: write 0xDEAD to idx 2 -> bresp SLVERR, read returns 0.
